// File: rtl/q_result_link.sv
// Purpose: arms the charge-measurement stage, captures its settled result and ships it as a two-byte 8N1 UART frame; flags stalled measurements with an error frame.
// Latency: ready sampled at cycle R -> start bit on tx at R+3; frame is 20*CLKS_PER_BIT cycles; frame end -> next meas_start rise is 3 cycles.
// Backpressure: none accepted; the measurement stage is paced by meas_start/meas_ready, and dropping enable aborts before SEND or stops after the frame.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   enable            level; keep cycling measure/transmit while high
//   meas_start        start to the measurement stage (registered)
//   meas_ready        ready from the measurement stage
//   meas_value        q_measured word from the measurement stage
//   tx                UART line, idle high (registered)
//   busy              high whenever the FSM is not in IDLE (registered)
//   timeout_flag      sticky; set on timeout, cleared on the next good capture
module q_result_link #(
    parameter int BUS_WIDTH    = 10,
    parameter int CLKS_PER_BIT = 16,
    parameter int TIMEOUT      = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    output logic                 meas_start,
    input  logic                 meas_ready,
    input  logic [BUS_WIDTH-1:0] meas_value,
    output logic                 tx,
    output logic                 busy,
    output logic                 timeout_flag
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [4:0]    FRAME_LAST = 5'd19;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_READY,
        SETTLE,
        SEND,
        REARM
    } state_t;

    state_t        state;
    logic [TW-1:0] tmo_cnt;
    logic [CW-1:0] clk_cnt;
    logic [4:0]    bit_idx;
    logic          phase;     // marks the second cycle of SETTLE / REARM
    logic [18:0]   tx_sh;     // frame bits still to go after the one on tx

    logic [15:0]   cap_word;
    logic [19:0]   data_frame;
    logic [19:0]   err_frame;

    // Both characters back to back, bit 0 first on the line:
    // start, high byte LSB first, stop, start, low byte LSB first, stop.
    function automatic logic [19:0] frame_of(input logic [15:0] w);
        return {1'b1, w[7:0], 1'b0, 1'b1, w[15:8], 1'b0};
    endfunction

    // Header 2'b10 marks data; it can never collide with the all-ones error word.
    assign cap_word   = {2'b10, 14'(meas_value)};
    assign data_frame = frame_of(cap_word);
    assign err_frame  = frame_of(16'hFFFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            meas_start   <= 1'b0;
            tx           <= 1'b1;
            busy         <= 1'b0;
            timeout_flag <= 1'b0;
            tmo_cnt      <= '0;
            clk_cnt      <= '0;
            bit_idx      <= '0;
            phase        <= 1'b0;
            tx_sh        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    meas_start <= 1'b0;
                    tx         <= 1'b1;
                    if (enable) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end

                ARM: begin
                    tmo_cnt <= '0;
                    if (!enable) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        meas_start <= 1'b0;
                    end else begin
                        state      <= WAIT_READY;
                        meas_start <= 1'b1;
                    end
                end

                WAIT_READY: begin
                    if (!enable) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        meas_start <= 1'b0;
                    end else if (meas_ready) begin
                        // ready outranks a timeout landing in the same cycle
                        state <= SETTLE;
                        phase <= 1'b0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_flag <= 1'b1;
                        state        <= SEND;
                        meas_start   <= 1'b0;
                        tx           <= err_frame[0];
                        tx_sh        <= err_frame[19:1];
                        clk_cnt      <= '0;
                        bit_idx      <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                SETTLE: begin
                    // q_measured lands one cycle after ready, so sample on the second cycle
                    if (!enable) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        meas_start <= 1'b0;
                    end else if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        timeout_flag <= 1'b0;
                        state        <= SEND;
                        meas_start   <= 1'b0;
                        tx           <= data_frame[0];
                        tx_sh        <= data_frame[19:1];
                        clk_cnt      <= '0;
                        bit_idx      <= '0;
                    end
                end

                SEND: begin
                    // enable is ignored here: a started frame always completes
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == FRAME_LAST) begin
                            state <= REARM;
                            phase <= 1'b0;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= tx_sh[0];
                            tx_sh   <= {1'b0, tx_sh[18:1]};
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                REARM: begin
                    // two cycles of start low let the measurement stage clear ready
                    meas_start <= 1'b0;
                    tx         <= 1'b1;
                    if (!phase) begin
                        phase <= 1'b1;
                    end else if (enable) begin
                        state <= ARM;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    meas_start <= 1'b0;
                    tx         <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q_result_link.sv
// Purpose: self-checking bench for q_result_link with a scoreboard of expected UART words.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_q_result_link;

    localparam int BW  = 10;
    localparam int CPB = 4;
    localparam int TMO = 16;
    localparam int NS  = 20 * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          meas_start;
    logic          meas_ready;
    logic [BW-1:0] meas_value;
    logic          tx;
    logic          busy;
    logic          timeout_flag;

    int            n_chk = 0;
    int            n_bad = 0;
    logic [15:0]   exp_q[$];

    q_result_link #(
        .BUS_WIDTH   (BW),
        .CLKS_PER_BIT(CPB),
        .TIMEOUT     (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .meas_start  (meas_start),
        .meas_ready  (meas_ready),
        .meas_value  (meas_value),
        .tx          (tx),
        .busy        (busy),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From IDLE: ARM one cycle after enable is sampled, meas_start one cycle later.
    task automatic start_from_idle();
        enable = 1'b1;
        tick();
        chk("arm_busy",    32'(busy),       32'd1);
        chk("arm_ms_low",  32'(meas_start), 32'd0);
        chk("arm_tx_idle", 32'(tx),         32'd1);
        tick();
        chk("arm_ms_high", 32'(meas_start), 32'd1);
    endtask

    // Called in the first WAIT_READY cycle; returns at SEND entry.
    task automatic measure(input int dly, input logic [BW-1:0] v_rdy, input logic [BW-1:0] v_set,
                           input logic [15:0] exp_w, input bit push, input logic tf_before);
        repeat (dly) tick();
        chk("wait_tx_idle", 32'(tx), 32'd1);
        meas_ready = 1'b1;
        meas_value = v_rdy;
        if (push) exp_q.push_back(exp_w);
        tick();
        meas_ready = 1'b0;
        meas_value = v_set;
        chk("settle_ms", 32'(meas_start), 32'd1);
        tick();
        chk("settle_tx", 32'(tx),           32'd1);
        chk("settle_tf", 32'(timeout_flag), 32'(tf_before));
        tick();
        meas_value = BW'($urandom);
        chk("capture_tf", 32'(timeout_flag), 32'd0);
    endtask

    // Samples every cycle of a frame starting at SEND entry; returns in the first REARM cycle.
    task automatic rx_frame(input int drop_at);
        logic [NS-1:0] s;
        logic [19:0]   fr;
        logic [15:0]   got;
        int            unstable;
        unstable = 0;
        chk("send_ms_low", 32'(meas_start), 32'd0);
        for (int i = 0; i < NS; i++) begin
            if (i == drop_at) enable = 1'b0;
            s[i] = tx;
            tick();
        end
        for (int b = 0; b < 20; b++) begin
            fr[b] = s[b*CPB];
            for (int k = 1; k < CPB; k++)
                if (s[b*CPB+k] !== fr[b]) unstable++;
        end
        chk("bit_timing", 32'(unstable), 32'd0);
        chk("framing", 32'({fr[0], fr[9], fr[10], fr[19]}), 32'h5);
        got = {fr[8:1], fr[18:11]};
        chk("sb_pending", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) chk("frame_word", 32'(got), 32'(exp_q.pop_front()));
    endtask

    task automatic check_rearm(input bit en);
        chk("rearm_ms",   32'(meas_start), 32'd0);
        chk("rearm_tx",   32'(tx),         32'd1);
        chk("rearm_busy", 32'(busy),       32'd1);
        tick();
        chk("rearm2_ms",  32'(meas_start), 32'd0);
        tick();
        if (en) begin
            chk("rearm_arm_ms",   32'(meas_start), 32'd0);
            chk("rearm_arm_busy", 32'(busy),       32'd1);
            tick();
            chk("rearm_restart",  32'(meas_start), 32'd1);
        end else begin
            chk("rearm_idle_busy", 32'(busy),       32'd0);
            chk("rearm_idle_ms",   32'(meas_start), 32'd0);
        end
    endtask

    task automatic do_timeout();
        int n;
        n = 0;
        exp_q.push_back(16'hFFFF);
        chk("tmo_tf_pre", 32'(timeout_flag), 32'd0);
        while (tx === 1'b1 && n < 3 * TMO) begin
            tick();
            n++;
        end
        chk("tmo_latency", 32'(n),            32'(TMO));
        chk("tmo_tf_set",  32'(timeout_flag), 32'd1);
    endtask

    initial begin
        int lows;
        int highs;
        rst        = 1'b1;
        enable     = 1'b0;
        meas_ready = 1'b0;
        meas_value = '0;

        repeat (2) tick();
        chk("rst_tx",   32'(tx),           32'd1);
        chk("rst_ms",   32'(meas_start),   32'd0);
        chk("rst_busy", 32'(busy),         32'd0);
        chk("rst_tf",   32'(timeout_flag), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Nominal capture: 390 -> 0x8186
        start_from_idle();
        measure(10, 10'd5, 10'd390, 16'h8186, 1'b1, 1'b0);
        rx_frame(-1);
        check_rearm(1'b1);

        // Value settles one cycle after ready: 0 then 1023 -> 0x83FF
        measure(4, 10'd0, 10'd1023, 16'h83FF, 1'b1, 1'b0);
        rx_frame(-1);
        check_rearm(1'b1);

        // Timeout -> error frame
        do_timeout();
        rx_frame(-1);
        check_rearm(1'b1);

        // Recovery: 30 -> 0x801E, flag clears at capture
        measure(6, 10'd30, 10'd30, 16'h801E, 1'b1, 1'b1);
        rx_frame(-1);
        check_rearm(1'b1);

        // Abort in WAIT_READY
        repeat (3) tick();
        enable = 1'b0;
        tick();
        chk("abort_ms",   32'(meas_start), 32'd0);
        chk("abort_busy", 32'(busy),       32'd0);
        chk("abort_tx",   32'(tx),         32'd1);
        lows  = 0;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
            if (meas_start !== 1'b0) highs++;
        end
        chk("abort_tx_quiet", 32'(lows),  32'd0);
        chk("abort_ms_quiet", 32'(highs), 32'd0);

        // Enable dropped mid-SEND: full frame, REARM, then IDLE
        start_from_idle();
        measure(2, 10'd700, 10'd700, 16'h82BC, 1'b1, 1'b0);
        rx_frame(30);
        check_rearm(1'b0);
        repeat (5) tick();
        chk("idle_stays", 32'(busy), 32'd0);

        // Async reset during data bits of the second byte
        start_from_idle();
        measure(3, 10'd512, 10'd512, 16'h8200, 1'b0, 1'b0);
        repeat (53) tick();
        chk("pre_rst_tx", 32'(tx), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_tx",   32'(tx),         32'd1);
        chk("async_rst_ms",   32'(meas_start), 32'd0);
        chk("async_rst_busy", 32'(busy),       32'd0);
        tick();
        tick();
        chk("rst_hold_tx", 32'(tx), 32'd1);
        rst = 1'b0;
        start_from_idle();
        measure(5, 10'd341, 10'd341, 16'h8155, 1'b1, 1'b0);
        rx_frame(-1);
        check_rearm(1'b1);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
